// File: rtl/fxp_shift_prep_if.sv
// ---------------------------------------------------------------------------
// fxp_shift_prep_if
// Handshake and data bundle for the fixed-point scaling right-shifter.
//   master : upstream/downstream environment (drives beats, accepts results)
//   slave  : the shifter itself
// Signals:
//   in_valid/in_ready   input beat handshake
//   in_sew              element width code (0=8,1=16,2=32,3=64 bits)
//   in_arith            1 = arithmetic shift, 0 = logical shift
//   vs2 / vs1           operand and per-element shift amounts
//   out_valid/out_ready output beat handshake
//   vec_out             truncated shifted elements
//   v_d/v_d1/v_d10      per-byte rounding information flags
// ---------------------------------------------------------------------------
interface fxp_shift_prep_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int DW_B = DATA_WIDTH / 8;

    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_sew;
    logic                  in_arith;
    logic [DATA_WIDTH-1:0] vs2;
    logic [DATA_WIDTH-1:0] vs1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] vec_out;
    logic [DW_B-1:0]       v_d;
    logic [DW_B-1:0]       v_d1;
    logic [DW_B-1:0]       v_d10;

    modport master (
        output in_valid, in_sew, in_arith, vs2, vs1, out_ready,
        input  in_ready, out_valid, vec_out, v_d, v_d1, v_d10
    );

    modport slave (
        input  in_valid, in_sew, in_arith, vs2, vs1, out_ready,
        output in_ready, out_valid, vec_out, v_d, v_d1, v_d10
    );
endinterface

// File: rtl/fxp_shift_prep.sv
// ---------------------------------------------------------------------------
// fxp_shift_prep
// Two-stage pipelined fixed-point scaling right-shifter (vssrl/vssra) that
// feeds the fixed-point rounding stage. Per element it produces the
// truncated shifted value plus the rounding bits v_d, v_d1, v_d10, placed in
// the lowest byte lane of each element.
//   S1: registers operand, per-element shift amount, sew, arith and the
//       rounding flags (low mask / sticky OR are computed on the way in).
//   S2: barrel shift, registers vec_out and flags.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   io   fxp_shift_prep_if.slave bundle (handshake, operands, results)
// Configuration:
//   FXP_SHIFT_ARITH_EN  defined   -> in_arith selects sign fill
//                       undefined -> all shifts logical, in_arith ignored
// ---------------------------------------------------------------------------
module fxp_shift_prep #(
    parameter int DATA_WIDTH = 64,
    parameter int DW_B       = DATA_WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    fxp_shift_prep_if.slave  io
);
    localparam int NCHUNK = DATA_WIDTH / 64;

    // Shift amount of every element modulo SEW, stored in its lowest byte lane
    // (6 bits per lane; non-lowest lanes stay zero).
    function automatic logic [47:0] lane_amts(input logic [63:0] amt_src,
                                              input logic [1:0]  sew);
        logic [47:0] res;
        int          w;
        res = 48'd0;
        w   = 32'd8 << sew;
        for (int e = 0; e < 8; e++) begin
            if (e < (32'd8 >> sew)) begin
                res[e * (w / 8) * 6 +: 6] = 6'(amt_src >> (e * w)) & 6'(w - 1);
            end
        end
        return res;
    endfunction

    // Rounding flags {v_d10, v_d1, v_d} for one 64-bit chunk.
    function automatic logic [23:0] lane_flags(input logic [63:0] data,
                                               input logic [47:0] amts,
                                               input logic [1:0]  sew);
        logic [7:0]  f_d;
        logic [7:0]  f_d1;
        logic [7:0]  f_d10;
        logic [63:0] wmask;
        logic [63:0] el;
        logic [63:0] low;
        logic [5:0]  d;
        int          w;
        int          lane;
        f_d   = 8'd0;
        f_d1  = 8'd0;
        f_d10 = 8'd0;
        w     = 32'd8 << sew;
        // 1 << 64 wraps to zero, so the 64-bit case yields all ones
        wmask = (64'd1 << w) - 64'd1;
        for (int e = 0; e < 8; e++) begin
            if (e < (32'd8 >> sew)) begin
                lane        = e * (w / 8);
                el          = (data >> (e * w)) & wmask;
                d           = amts[lane * 6 +: 6];
                low         = (64'd1 << d) - 64'd1;
                f_d[lane]   = el[d];
                f_d1[lane]  = (d == 6'd0) ? 1'b0 : el[d - 6'd1];
                f_d10[lane] = |(el & low);
            end
        end
        return {f_d10, f_d1, f_d};
    endfunction

    // Element-wise right shift of one 64-bit chunk. For sign fill the element
    // is extended with ones above its MSB so the logical shift pulls them in.
    function automatic logic [63:0] lane_shift(input logic [63:0] data,
                                               input logic [47:0] amts,
                                               input logic [1:0]  sew,
                                               input logic        fill_en);
        logic [63:0] res;
        logic [63:0] wmask;
        logic [63:0] el;
        logic [5:0]  d;
        int          w;
        res   = 64'd0;
        w     = 32'd8 << sew;
        wmask = (64'd1 << w) - 64'd1;
        for (int e = 0; e < 8; e++) begin
            if (e < (32'd8 >> sew)) begin
                el = (data >> (e * w)) & wmask;
                d  = amts[e * (w / 8) * 6 +: 6];
                if (fill_en && el[w - 1]) begin
                    el = el | ~wmask;
                end
                res = res | (((el >> d) & wmask) << (e * w));
            end
        end
        return res;
    endfunction

    logic                  s1_valid_r;
    logic [DATA_WIDTH-1:0] s1_data_r;
    logic [DW_B*6-1:0]     s1_amt_r;
    logic [1:0]            s1_sew_r;
    logic [DW_B-1:0]       s1_fd_r;
    logic [DW_B-1:0]       s1_fd1_r;
    logic [DW_B-1:0]       s1_fd10_r;

    logic                  s2_valid_r;
    logic [DATA_WIDTH-1:0] s2_vec_r;
    logic [DW_B-1:0]       s2_fd_r;
    logic [DW_B-1:0]       s2_fd1_r;
    logic [DW_B-1:0]       s2_fd10_r;

    logic                  s1_adv_s;
    logic                  s2_adv_s;
    logic                  fill_s;
    logic [DW_B*6-1:0]     in_amt_s;
    logic [DW_B-1:0]       in_fd_s;
    logic [DW_B-1:0]       in_fd1_s;
    logic [DW_B-1:0]       in_fd10_s;
    logic [23:0]           chunk_flags_s;
    logic [DATA_WIDTH-1:0] shift_s;

    assign s2_adv_s = !s2_valid_r || io.out_ready;
    assign s1_adv_s = !s1_valid_r || s2_adv_s;

`ifdef FXP_SHIFT_ARITH_EN
    logic s1_arith_r;

    // Arithmetic-select register, advancing with the rest of S1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_arith_r <= 1'b0;
        end else if (s1_adv_s && io.in_valid) begin
            s1_arith_r <= io.in_arith;
        end
    end

    assign fill_s = s1_arith_r;
`else
    logic unused_arith_s;
    assign unused_arith_s = io.in_arith;
    // tied low so the sign-fill path folds away entirely
    assign fill_s = 1'b0;
`endif

    // S1 front end: per-element shift amounts, low mask and sticky OR
    always_comb begin
        in_amt_s      = '0;
        in_fd_s       = '0;
        in_fd1_s      = '0;
        in_fd10_s     = '0;
        chunk_flags_s = 24'd0;
        for (int c = 0; c < NCHUNK; c++) begin
            in_amt_s[c * 48 +: 48] = lane_amts(io.vs1[c * 64 +: 64], io.in_sew);
            chunk_flags_s          = lane_flags(io.vs2[c * 64 +: 64],
                                                in_amt_s[c * 48 +: 48], io.in_sew);
            in_fd_s[c * 8 +: 8]    = chunk_flags_s[7:0];
            in_fd1_s[c * 8 +: 8]   = chunk_flags_s[15:8];
            in_fd10_s[c * 8 +: 8]  = chunk_flags_s[23:16];
        end
    end

    // S1 pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_amt_r   <= '0;
            s1_sew_r   <= 2'd0;
            s1_fd_r    <= '0;
            s1_fd1_r   <= '0;
            s1_fd10_r  <= '0;
        end else if (s1_adv_s) begin
            s1_valid_r <= io.in_valid;
            if (io.in_valid) begin
                s1_data_r <= io.vs2;
                s1_amt_r  <= in_amt_s;
                s1_sew_r  <= io.in_sew;
                s1_fd_r   <= in_fd_s;
                s1_fd1_r  <= in_fd1_s;
                s1_fd10_r <= in_fd10_s;
            end
        end
    end

    // S2 barrel shift
    always_comb begin
        shift_s = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            shift_s[c * 64 +: 64] = lane_shift(s1_data_r[c * 64 +: 64],
                                               s1_amt_r[c * 48 +: 48],
                                               s1_sew_r, fill_s);
        end
    end

    // S2 output register; holds its beat while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            s2_vec_r   <= '0;
            s2_fd_r    <= '0;
            s2_fd1_r   <= '0;
            s2_fd10_r  <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_vec_r  <= shift_s;
                s2_fd_r   <= s1_fd_r;
                s2_fd1_r  <= s1_fd1_r;
                s2_fd10_r <= s1_fd10_r;
            end
        end
    end

    assign io.in_ready  = s1_adv_s;
    assign io.out_valid = s2_valid_r;
    assign io.vec_out   = s2_vec_r;
    assign io.v_d       = s2_fd_r;
    assign io.v_d1      = s2_fd1_r;
    assign io.v_d10     = s2_fd10_r;

endmodule
